// File: rtl/ibex_pext_mac_sequencer_if.sv
// Request, result and shared-multiplier signals of the P-extension MAC sequencer.
// The sequencer is the slave; the core/multiplier side (or a bench) is the master.
interface ibex_pext_mac_sequencer_if;
  logic               start_i;
  logic               kill_i;
  logic [1:0]         op_i;
  logic               round_i;
  logic [31:0]        op_a_i;
  logic [31:0]        op_b_i;
  logic [31:0]        acc_i;

  logic               mul_req_o;
  logic               mul_gnt_i;
  logic [16:0]        mul_a_o;
  logic [16:0]        mul_b_o;
  logic [33:0]        mul_res_i;

  logic               busy_o;
  logic               valid_o;
  logic [31:0]        result_o;
  logic               ov_o;

  modport slave (
    input  start_i, kill_i, op_i, round_i, op_a_i, op_b_i, acc_i,
    input  mul_gnt_i, mul_res_i,
    output mul_req_o, mul_a_o, mul_b_o,
    output busy_o, valid_o, result_o, ov_o
  );

  modport master (
    output start_i, kill_i, op_i, round_i, op_a_i, op_b_i, acc_i,
    output mul_gnt_i, mul_res_i,
    input  mul_req_o, mul_a_o, mul_b_o,
    input  busy_o, valid_o, result_o, ov_o
  );
endinterface

// File: rtl/ibex_pext_mac_sequencer.sv
// Multi-cycle 32x32 multiply-accumulate built from four 17x17 partial products on a
// shared multiplier: MADDR32/MSUBR32 (low word) and KMMAC/KMMSB (saturating high word).
module ibex_pext_mac_sequencer (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  ibex_pext_mac_sequencer_if.slave         bus
);

  typedef enum logic [2:0] {
    IDLE,
    MUL0,
    MUL1,
    MUL2,
    MUL3,
    ACC,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_MADDR32 = 2'b00,
    OP_MSUBR32 = 2'b01,
    OP_KMMAC   = 2'b10,
    OP_KMMSB   = 2'b11
  } op_e;

  state_e      state_q,   state_d;
  op_e         op_q,      op_d;
  logic        round_q,   round_d;
  logic [31:0] a_q,       a_d;
  logic [31:0] b_q,       b_d;
  logic [31:0] acc_q,     acc_d;
  logic [63:0] psum_q,    psum_d;
  logic [31:0] result_q,  result_d;
  logic        ov_q,      ov_d;
  logic        busy_q,    busy_d;
  logic        valid_q,   valid_d;
  logic        mul_req_q, mul_req_d;
  logic [16:0] mul_a_q,   mul_a_d;
  logic [16:0] mul_b_q,   mul_b_d;

  logic [63:0] step_ext;
  logic [32:0] h_sum;
  logic [33:0] acc_ext;
  logic [33:0] h_ext;
  logic [33:0] kmm_sum;
  logic        kmm_sat_hi;
  logic        kmm_sat_lo;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch can be inferred.
    state_d  = state_q;
    op_d     = op_q;
    round_d  = round_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    psum_d   = psum_q;
    result_d = result_q;
    ov_d     = ov_q;
    mul_a_d  = '0;
    mul_b_d  = '0;

    step_ext = {{30{bus.mul_res_i[33]}}, bus.mul_res_i};

    // High word of the product with optional round-half-up, widened so acc +/- H cannot wrap.
    h_sum      = {psum_q[63], psum_q[63:32]} + {32'd0, round_q & psum_q[31]};
    acc_ext    = {{2{acc_q[31]}}, acc_q};
    h_ext      = {h_sum[32], h_sum};
    kmm_sum    = (op_q == OP_KMMSB) ? (acc_ext - h_ext) : (acc_ext + h_ext);
    kmm_sat_hi = ~kmm_sum[33] & (kmm_sum[32:31] != 2'b00);
    kmm_sat_lo =  kmm_sum[33] & (kmm_sum[32:31] != 2'b11);

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          op_d    = op_e'(bus.op_i);
          round_d = bus.round_i;
          a_d     = bus.op_a_i;
          b_d     = bus.op_b_i;
          acc_d   = bus.acc_i;
          psum_d  = '0;
          state_d = MUL0;
        end
      end
      MUL0: begin
        if (bus.mul_gnt_i) begin
          psum_d  = psum_q + step_ext;
          state_d = MUL1;
        end
      end
      MUL1: begin
        if (bus.mul_gnt_i) begin
          psum_d  = psum_q + (step_ext << 16);
          state_d = MUL2;
        end
      end
      MUL2: begin
        if (bus.mul_gnt_i) begin
          psum_d  = psum_q + (step_ext << 16);
          // Low-word ops never need Ah*Bh: it only contributes above bit 31.
          state_d = op_q[1] ? MUL3 : ACC;
        end
      end
      MUL3: begin
        if (bus.mul_gnt_i) begin
          psum_d  = psum_q + (step_ext << 32);
          state_d = ACC;
        end
      end
      ACC: begin
        unique case (op_q)
          OP_MADDR32: begin
            result_d = acc_q + psum_q[31:0];
            ov_d     = 1'b0;
          end
          OP_MSUBR32: begin
            result_d = acc_q - psum_q[31:0];
            ov_d     = 1'b0;
          end
          default: begin
            if (kmm_sat_hi) begin
              result_d = 32'h7FFF_FFFF;
            end else if (kmm_sat_lo) begin
              result_d = 32'h8000_0000;
            end else begin
              result_d = kmm_sum[31:0];
            end
            ov_d = kmm_sat_hi | kmm_sat_lo;
          end
        endcase
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush wins over any grant or advance; the partial result is simply dropped.
    if (bus.kill_i && (state_q != IDLE)) begin
      state_d  = IDLE;
      psum_d   = psum_q;
      result_d = result_q;
      ov_d     = ov_q;
    end

    // Outputs are registered, so they are derived from the state being entered.
    busy_d    = (state_d != IDLE);
    valid_d   = (state_d == DONE);
    mul_req_d = (state_d inside {MUL0, MUL1, MUL2, MUL3});

    unique case (state_d)
      MUL0: begin
        mul_a_d = {1'b0, a_d[15:0]};
        mul_b_d = {1'b0, b_d[15:0]};
      end
      MUL1: begin
        mul_a_d = {1'b0, a_d[15:0]};
        mul_b_d = {b_d[31], b_d[31:16]};
      end
      MUL2: begin
        mul_a_d = {a_d[31], a_d[31:16]};
        mul_b_d = {1'b0, b_d[15:0]};
      end
      MUL3: begin
        mul_a_d = {a_d[31], a_d[31:16]};
        mul_b_d = {b_d[31], b_d[31:16]};
      end
      default: begin
        mul_a_d = '0;
        mul_b_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      op_q      <= OP_MADDR32;
      round_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      psum_q    <= '0;
      result_q  <= '0;
      ov_q      <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      mul_req_q <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      round_q   <= round_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      psum_q    <= psum_d;
      result_q  <= result_d;
      ov_q      <= ov_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      mul_req_q <= mul_req_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.valid_o   = valid_q;
  assign bus.result_o  = result_q;
  assign bus.ov_o      = ov_q;
  assign bus.mul_req_o = mul_req_q;
  assign bus.mul_a_o   = mul_a_q;
  assign bus.mul_b_o   = mul_b_q;

endmodule

// File: tb/tb_ibex_pext_mac_sequencer.sv
// Bench for ibex_pext_mac_sequencer: acts as core and shared multiplier, and checks
// results, latency and handshakes against a 64-bit arithmetic model of each op.
module tb_ibex_pext_mac_sequencer;

  logic clk_i = 1'b0;
  logic rst_ni;

  ibex_pext_mac_sequencer_if bus();

  ibex_pext_mac_sequencer dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  // Shared 17x17 signed multiplier, combinational.
  logic signed [33:0] mul_a_ext;
  logic signed [33:0] mul_b_ext;
  assign mul_a_ext     = $signed(bus.mul_a_o);
  assign mul_b_ext     = $signed(bus.mul_b_o);
  assign bus.mul_res_i = mul_a_ext * mul_b_ext;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] last_res    = '0;
  logic        last_ov     = 1'b0;

  localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint SMIN = -64'sh0000_0000_8000_0000;

  // Returns {ov, result} from the full 64-bit signed product.
  function automatic logic [32:0] ref_model(input logic [1:0] op, input logic rnd,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] acc);
    longint      p;
    longint      h;
    longint      s;
    logic [31:0] plo;
    logic [31:0] r;
    logic        o;
    p   = longint'($signed(a)) * longint'($signed(b));
    plo = p[31:0];
    if (!op[1]) begin
      r = op[0] ? (acc - plo) : (acc + plo);
      o = 1'b0;
    end else begin
      h = (p >>> 32) + ((rnd && p[31]) ? 64'sd1 : 64'sd0);
      s = op[0] ? (longint'($signed(acc)) - h) : (longint'($signed(acc)) + h);
      if (s > SMAX) begin
        r = 32'h7FFF_FFFF;
        o = 1'b1;
      end else if (s < SMIN) begin
        r = 32'h8000_0000;
        o = 1'b1;
      end else begin
        r = s[31:0];
        o = 1'b0;
      end
    end
    return {o, r};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic scramble_inputs();
    bus.op_i    = 2'($urandom);
    bus.round_i = 1'($urandom);
    bus.op_a_i  = $urandom;
    bus.op_b_i  = $urandom;
    bus.acc_i   = $urandom;
  endtask

  // gpat bit i is the grant offered in the i-th cycle after the start is accepted.
  task automatic run_op(input logic [1:0] op, input logic rnd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] acc, input logic [31:0] gpat,
                        input logic [31:0] exp_res, input logic exp_ov, input string name);
    int          need;
    int          grants;
    int          k;
    int          exp_lat;
    int          seen_lat;
    int          req_cycles;
    int          valid_cnt;
    logic        opnd_bad;
    logic [31:0] res_at_valid;
    logic        ov_at_valid;
    need   = op[1] ? 4 : 3;
    grants = 0;
    k      = 0;
    for (int i = 0; i < 32; i++) begin
      if (grants < need) begin
        if (gpat[i]) grants++;
        k = i + 1;
      end
    end
    exp_lat = k + 2;

    @(negedge clk_i);
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.round_i   = rnd;
    bus.op_a_i    = a;
    bus.op_b_i    = b;
    bus.acc_i     = acc;
    bus.mul_gnt_i = 1'b0;
    seen_lat      = -1;
    req_cycles    = 0;
    valid_cnt     = 0;
    opnd_bad      = 1'b0;
    res_at_valid  = '0;
    ov_at_valid   = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_i);
      if (c == 1) begin
        bus.start_i = 1'b0;
        scramble_inputs();
      end
      if (bus.mul_req_o) req_cycles++;
      else if ((bus.mul_a_o != '0) || (bus.mul_b_o != '0)) opnd_bad = 1'b1;
      if (bus.valid_o) begin
        valid_cnt++;
        if (seen_lat < 0) begin
          seen_lat     = c;
          res_at_valid = bus.result_o;
          ov_at_valid  = bus.ov_o;
        end
      end
      bus.mul_gnt_i = (c <= 32) ? gpat[c-1] : 1'b1;
    end

    vectors++;
    if (seen_lat !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d expected %0d", name, seen_lat, exp_lat);
    end
    vectors++;
    if (res_at_valid !== exp_res) begin
      miscompares++;
      $display("FAIL %s result: got %h expected %h", name, res_at_valid, exp_res);
    end
    vectors++;
    if (ov_at_valid !== exp_ov) begin
      miscompares++;
      $display("FAIL %s ov: got %b expected %b", name, ov_at_valid, exp_ov);
    end
    vectors++;
    if (valid_cnt !== 1) begin
      miscompares++;
      $display("FAIL %s valid pulses: got %0d expected 1", name, valid_cnt);
    end
    vectors++;
    if (req_cycles !== k) begin
      miscompares++;
      $display("FAIL %s mul_req cycles: got %0d expected %0d", name, req_cycles, k);
    end
    vectors++;
    if (opnd_bad !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle operands: got nonzero expected zero", name);
    end
    vectors++;
    if ((bus.result_o !== exp_res) || (bus.busy_o !== 1'b0)) begin
      miscompares++;
      $display("FAIL %s held result/busy: got %h/%b expected %h/0", name, bus.result_o,
               bus.busy_o, exp_res);
    end
    last_res = exp_res;
    last_ov  = exp_ov;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    vectors++;
    if ({bus.busy_o, bus.valid_o, bus.mul_req_o, bus.ov_o} !== 4'b0000 ||
        bus.result_o !== 32'd0 || bus.mul_a_o !== 17'd0 || bus.mul_b_o !== 17'd0) begin
      miscompares++;
      $display("FAIL reset outputs: got busy=%b valid=%b req=%b ov=%b res=%h expected all 0",
               bus.busy_o, bus.valid_o, bus.mul_req_o, bus.ov_o, bus.result_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (bus.busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset release busy: got %b expected 0", bus.busy_o);
    end
  endtask

  task automatic test_directed();
    run_op(2'b00, 1'b0, 32'd3, 32'd4, 32'd5, 32'hFFFF_FFFF, 32'd17, 1'b0, "maddr32");
    run_op(2'b10, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'd1, 32'hFFFF_FFFF,
           32'h1000_0001, 1'b0, "kmmac");
    run_op(2'b10, 1'b1, 32'h0001_0000, 32'h0000_8000, 32'd0, 32'hFFFF_FFFF,
           32'd1, 1'b0, "kmmac_round1");
    run_op(2'b10, 1'b0, 32'h0001_0000, 32'h0000_8000, 32'd0, 32'hFFFF_FFFF,
           32'd0, 1'b0, "kmmac_round0");
    run_op(2'b10, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
           32'h7FFF_FFFF, 1'b1, "kmmac_sat");
    run_op(2'b11, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1'b1, "kmmsb_sat");
    run_op(2'b01, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd10, 32'hFFFF_FFFF, 32'd12, 1'b0, "msubr32");
  endtask

  task automatic test_stall();
    logic [32:0] m;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] acc;
    a   = $urandom;
    b   = $urandom;
    acc = $urandom;
    m   = ref_model(2'b10, 1'b0, a, b, acc);
    // Grant in MUL0, then three refused cycles while in MUL1: valid lands at T+9.
    run_op(2'b10, 1'b0, a, b, acc, 32'hFFFF_FFF1, m[31:0], m[32], "kmmac_stall");
  endtask

  task automatic test_random();
    logic [32:0] m;
    logic [1:0]  op;
    logic        rnd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] acc;
    logic [31:0] gpat;
    for (int n = 0; n < 30; n++) begin
      op   = 2'($urandom);
      rnd  = 1'($urandom);
      a    = pick();
      b    = pick();
      acc  = pick();
      gpat = (n % 2 == 0) ? 32'hFFFF_FFFF : {16'hFFFF, 16'($urandom)};
      m    = ref_model(op, rnd, a, b, acc);
      run_op(op, rnd, a, b, acc, gpat, m[31:0], m[32], "random");
    end
  endtask

  task automatic test_back_to_back();
    int v1;
    int v2;
    int vc;
    @(negedge clk_i);
    bus.start_i   = 1'b1;
    bus.op_i      = 2'b00;
    bus.round_i   = 1'b0;
    bus.op_a_i    = 32'd3;
    bus.op_b_i    = 32'd4;
    bus.acc_i     = 32'd5;
    bus.mul_gnt_i = 1'b1;
    v1 = -1;
    v2 = -1;
    vc = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk_i);
      if (c == 7) bus.start_i = 1'b0;
      if (bus.valid_o) begin
        vc++;
        if (v1 < 0) v1 = c;
        else if (v2 < 0) v2 = c;
      end
    end
    vectors++;
    if ((v1 !== 5) || (v2 !== 11) || (vc !== 2)) begin
      miscompares++;
      $display("FAIL back_to_back valid cycles: got %0d,%0d (n=%0d) expected 5,11 (n=2)",
               v1, v2, vc);
    end
    vectors++;
    if (bus.result_o !== 32'd17) begin
      miscompares++;
      $display("FAIL back_to_back result: got %h expected %h", bus.result_o, 32'd17);
    end
    last_res = 32'd17;
    last_ov  = 1'b0;
  endtask

  task automatic test_kill();
    int valid_cnt;
    @(negedge clk_i);
    bus.start_i   = 1'b1;
    bus.op_i      = 2'b10;
    bus.round_i   = 1'b1;
    bus.op_a_i    = $urandom;
    bus.op_b_i    = $urandom;
    bus.acc_i     = $urandom;
    bus.mul_gnt_i = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    bus.kill_i = 1'b1;
    @(negedge clk_i);
    bus.kill_i = 1'b0;
    vectors++;
    if ((bus.busy_o !== 1'b0) || (bus.mul_req_o !== 1'b0)) begin
      miscompares++;
      $display("FAIL kill idle: got busy=%b req=%b expected 0/0", bus.busy_o, bus.mul_req_o);
    end
    valid_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.valid_o) valid_cnt++;
      @(negedge clk_i);
    end
    vectors++;
    if (valid_cnt !== 0) begin
      miscompares++;
      $display("FAIL kill valid: got %0d pulses expected 0", valid_cnt);
    end
    vectors++;
    if ((bus.result_o !== last_res) || (bus.ov_o !== last_ov)) begin
      miscompares++;
      $display("FAIL kill result held: got %h/%b expected %h/%b", bus.result_o, bus.ov_o,
               last_res, last_ov);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk_i);
    bus.start_i   = 1'b1;
    bus.op_i      = 2'b10;
    bus.op_a_i    = 32'h1234_5678;
    bus.op_b_i    = 32'h8765_4321;
    bus.acc_i     = 32'h0BAD_F00D;
    bus.mul_gnt_i = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    vectors++;
    if ({bus.busy_o, bus.valid_o, bus.mul_req_o, bus.ov_o} !== 4'b0000 ||
        bus.result_o !== 32'd0 || bus.mul_a_o !== 17'd0 || bus.mul_b_o !== 17'd0) begin
      miscompares++;
      $display("FAIL mid-op reset outputs: got busy=%b valid=%b req=%b ov=%b res=%h expected all 0",
               bus.busy_o, bus.valid_o, bus.mul_req_o, bus.ov_o, bus.result_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    last_res = '0;
    last_ov  = 1'b0;
    run_op(2'b00, 1'b0, 32'd3, 32'd4, 32'd5, 32'hFFFF_FFFF, 32'd17, 1'b0, "after_reset");
  endtask

  initial begin
    // Watchdog: a hung DUT still produces a report instead of a silent hang.
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // NOTE: stimulus uses blocking assignments at the falling edge, away from the sampling edge.
    bus.start_i   = 1'b0;
    bus.kill_i    = 1'b0;
    bus.op_i      = 2'b00;
    bus.round_i   = 1'b0;
    bus.op_a_i    = '0;
    bus.op_b_i    = '0;
    bus.acc_i     = '0;
    bus.mul_gnt_i = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_kill();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
